// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between the instruction-fetch and data-memory
// requesters of a core. One transaction is in flight at a time and it always
// runs accept -> issue -> wait for response -> return.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : on a simultaneous request the
//                                       requester not granted last wins.
//                           undefined : fixed priority, data wins ties.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   instr_req_i / instr_addr_i      fetch request and address
//   instr_gnt_o                     fetch accept pulse (combinational, IDLE only)
//   instr_rvalid_o / instr_rdata_o  fetch response pulse and data
//   data_req_i / data_addr_i        load/store request and address
//   data_byte_en_i / data_wr_i      access size code, 1 = store
//   data_wr_data_i                  store data
//   data_gnt_o                      load/store accept pulse
//   data_rvalid_o / data_rdata_o    load data valid or store complete, load data
//   mem_req_o                       shared-port request, high in ISSUE
//   mem_addr_o .. mem_wr_data_o     latched transaction fields
//   mem_gnt_i                       memory accepts mem_req_o
//   mem_rvalid_i / mem_rdata_i      memory response and data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,

    input  logic              data_req_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [1:0]        data_byte_en_i,
    input  logic              data_wr_i,
    input  logic [DATA_W-1:0] data_wr_data_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,

    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_byte_en_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          byte_en_q, byte_en_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   instr_rdata_q, instr_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                instr_rvalid_q, instr_rvalid_d;
    logic                data_rvalid_q, data_rvalid_d;

    logic                can_grant;
    logic                pick_data;
    logic                grant_instr;
    logic                grant_data;

    // Grants are only offered from IDLE; gating with reset keeps the
    // combinational accept pulses low while the block is held in reset.
    assign can_grant = (state_q == IDLE) && !reset;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 0 = instr granted last, 1 = data granted last.
    logic last_grant_q, last_grant_d;

    // On a tie the data side wins only if instr was granted last.
    assign pick_data = data_req_i && (!instr_req_i || (last_grant_q == OWNER_INSTR));

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_data) begin
            last_grant_d = OWNER_DATA;
        end else if (grant_instr) begin
            last_grant_d = OWNER_INSTR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= OWNER_INSTR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign pick_data = data_req_i;
`endif

    assign grant_data  = can_grant && pick_data;
    assign grant_instr = can_grant && instr_req_i && !pick_data;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        byte_en_d      = byte_en_q;
        wr_d           = wr_q;
        wr_data_d      = wr_data_q;
        instr_rdata_d  = instr_rdata_q;
        data_rdata_d   = data_rdata_q;
        instr_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d   = ISSUE;
                    owner_d   = OWNER_DATA;
                    addr_d    = data_addr_i;
                    byte_en_d = data_byte_en_i;
                    wr_d      = data_wr_i;
                    wr_data_d = data_wr_data_i;
                end else if (grant_instr) begin
                    // Fetches are always full-width reads.
                    state_d   = ISSUE;
                    owner_d   = OWNER_INSTR;
                    addr_d    = instr_addr_i;
                    byte_en_d = 2'b11;
                    wr_d      = 1'b0;
                    wr_data_d = '0;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    if (owner_q == OWNER_DATA) begin
                        data_rdata_d  = mem_rdata_i;
                        data_rvalid_d = 1'b1;
                    end else begin
                        instr_rdata_d  = mem_rdata_i;
                        instr_rvalid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= OWNER_INSTR;
            addr_q         <= '0;
            byte_en_q      <= '0;
            wr_q           <= 1'b0;
            wr_data_q      <= '0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            byte_en_q      <= byte_en_d;
            wr_q           <= wr_d;
            wr_data_q      <= wr_data_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rdata_q   <= data_rdata_d;
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
        end
    end

    // Derived from the state register so it drops as soon as reset asserts.
    assign mem_req_o      = (state_q == ISSUE);
    assign mem_addr_o     = addr_q;
    assign mem_byte_en_o  = byte_en_q;
    assign mem_wr_o       = wr_q;
    assign mem_wr_data_o  = wr_data_q;

    assign instr_gnt_o    = grant_instr;
    assign data_gnt_o     = grant_data;
    assign instr_rvalid_o = instr_rvalid_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign data_rdata_o   = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Inputs change 1 time unit after the rising
// edge; registered outputs are checked there, combinational grants 1 unit
// later once the new inputs have settled.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk;
    logic              reset;
    logic              instr_req_i;
    logic [ADDR_W-1:0] instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [DATA_W-1:0] instr_rdata_o;
    logic              data_req_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [1:0]        data_byte_en_i;
    logic              data_wr_i;
    logic [DATA_W-1:0] data_wr_data_i;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [DATA_W-1:0] data_rdata_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [1:0]        mem_byte_en_o;
    logic              mem_wr_o;
    logic [DATA_W-1:0] mem_wr_data_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    int n_cmp;
    int n_err;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_byte_en_i (data_byte_en_i),
        .data_wr_i      (data_wr_i),
        .data_wr_data_i (data_wr_data_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_byte_en_o  (mem_byte_en_o),
        .mem_wr_o       (mem_wr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".instr_rvalid"}, 64'(instr_rvalid_o), 64'd0);
        check_eq({tag, ".data_rvalid"},  64'(data_rvalid_o),  64'd0);
    endtask

    logic exp_data_wins;

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        instr_req_i    = 1'b0;
        instr_addr_i   = '0;
        data_req_i     = 1'b0;
        data_addr_i    = '0;
        data_byte_en_i = 2'b00;
        data_wr_i      = 1'b0;
        data_wr_data_i = '0;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = '0;

        tick();
        tick();
        // ---- reset state ----
        check_eq("rst.mem_req",     64'(mem_req_o),     64'd0);
        check_eq("rst.mem_addr",    mem_addr_o,         64'd0);
        check_eq("rst.mem_byte_en", 64'(mem_byte_en_o), 64'd0);
        check_eq("rst.instr_rdata", instr_rdata_o,      64'd0);
        check_eq("rst.data_rdata",  data_rdata_o,       64'd0);
        check_quiet("rst");
        reset = 1'b0;
        tick();

        // ---- single fetch, immediate grant ----
        instr_req_i  = 1'b1;
        instr_addr_i = 64'h1000;
        settle();
        check_eq("fetch.c0.instr_gnt", 64'(instr_gnt_o), 64'd1);
        check_eq("fetch.c0.data_gnt",  64'(data_gnt_o),  64'd0);
        tick();
        instr_req_i = 1'b0;
        mem_gnt_i   = 1'b1;
        check_eq("fetch.c1.mem_req",     64'(mem_req_o),     64'd1);
        check_eq("fetch.c1.mem_addr",    mem_addr_o,         64'h1000);
        check_eq("fetch.c1.mem_wr",      64'(mem_wr_o),      64'd0);
        check_eq("fetch.c1.mem_byte_en", 64'(mem_byte_en_o), 64'd3);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD_BEEF_0000_0013;
        check_eq("fetch.c2.mem_req", 64'(mem_req_o), 64'd0);
        check_quiet("fetch.c2");
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        check_eq("fetch.c3.instr_rvalid", 64'(instr_rvalid_o), 64'd1);
        check_eq("fetch.c3.instr_rdata",  instr_rdata_o,       64'hDEAD_BEEF_0000_0013);
        check_eq("fetch.c3.data_rvalid",  64'(data_rvalid_o),  64'd0);
        tick();
        check_quiet("fetch.c4");

        // ---- store with two wait cycles on mem_gnt_i ----
        data_req_i     = 1'b1;
        data_addr_i    = 64'h2008;
        data_wr_i      = 1'b1;
        data_wr_data_i = 64'h55;
        data_byte_en_i = 2'b10;
        settle();
        check_eq("store.c0.data_gnt", 64'(data_gnt_o), 64'd1);
        tick();
        // Changes after grant must not reach the memory port.
        data_req_i     = 1'b0;
        data_addr_i    = 64'hFFFF;
        data_wr_data_i = 64'hAA;
        data_byte_en_i = 2'b01;
        data_wr_i      = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mem_gnt_i = (c == 3);
            check_eq($sformatf("store.c%0d.mem_req", c),     64'(mem_req_o),     64'd1);
            check_eq($sformatf("store.c%0d.mem_addr", c),    mem_addr_o,         64'h2008);
            check_eq($sformatf("store.c%0d.mem_wr", c),      64'(mem_wr_o),      64'd1);
            check_eq($sformatf("store.c%0d.mem_wr_data", c), mem_wr_data_o,      64'h55);
            check_eq($sformatf("store.c%0d.mem_byte_en", c), 64'(mem_byte_en_o), 64'd2);
            tick();
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h77;
        check_eq("store.c4.mem_req", 64'(mem_req_o), 64'd0);
        tick();
        mem_rvalid_i = 1'b0;
        check_eq("store.c5.data_rvalid",  64'(data_rvalid_o),  64'd1);
        check_eq("store.c5.data_rdata",   data_rdata_o,        64'h77);
        check_eq("store.c5.instr_rvalid", 64'(instr_rvalid_o), 64'd0);
        check_eq("store.c5.instr_rdata",  instr_rdata_o,       64'hDEAD_BEEF_0000_0013);
        tick();
        check_quiet("store.c6");

        // ---- simultaneous requests held over four transactions ----
        instr_req_i  = 1'b1;
        instr_addr_i = 64'h3000;
        data_req_i   = 1'b1;
        data_addr_i  = 64'h4000;
        data_wr_i    = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_data_wins = ((k % 2) == 0);
`else
            exp_data_wins = 1'b1;
`endif
            settle();
            check_eq($sformatf("tie%0d.data_gnt", k),  64'(data_gnt_o),  64'(exp_data_wins));
            check_eq($sformatf("tie%0d.instr_gnt", k), 64'(instr_gnt_o), 64'(!exp_data_wins));
            tick();
            mem_gnt_i = 1'b1;
            check_eq($sformatf("tie%0d.mem_addr", k), mem_addr_o,
                     exp_data_wins ? 64'h4000 : 64'h3000);
            tick();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 64'h100 + 64'(k);
            tick();
            mem_rvalid_i = 1'b0;
            check_eq($sformatf("tie%0d.data_rvalid", k),  64'(data_rvalid_o),  64'(exp_data_wins));
            check_eq($sformatf("tie%0d.instr_rvalid", k), 64'(instr_rvalid_o), 64'(!exp_data_wins));
        end
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        tick();

        // ---- async reset while in ISSUE ----
        instr_req_i  = 1'b1;
        instr_addr_i = 64'h6000;
        tick();
        instr_req_i = 1'b0;
        check_eq("rstiss.mem_req_before", 64'(mem_req_o), 64'd1);
        reset = 1'b1;
        settle();
        check_eq("rstiss.mem_req_async", 64'(mem_req_o), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // ---- reset while in RESP ----
        data_req_i     = 1'b1;
        data_addr_i    = 64'h5000;
        data_wr_i      = 1'b0;
        data_byte_en_i = 2'b11;
        tick();
        data_req_i = 1'b0;
        mem_gnt_i  = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        reset     = 1'b1;
        settle();
        check_eq("rstresp.mem_req",  64'(mem_req_o),  64'd0);
        check_eq("rstresp.mem_addr", mem_addr_o,      64'd0);
        check_eq("rstresp.d_rdata",  data_rdata_o,    64'd0);
        check_eq("rstresp.i_rdata",  instr_rdata_o,   64'd0);
        tick();
        reset = 1'b0;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hBAD;
        tick();
        mem_rvalid_i = 1'b0;
        check_quiet("rstresp.late");
        check_eq("rstresp.late.mem_req", 64'(mem_req_o), 64'd0);
        tick();
        check_quiet("rstresp.late2");
        check_eq("rstresp.late2.d_rdata", data_rdata_o, 64'd0);

        // ---- spurious mem_rvalid_i / mem_gnt_i in IDLE ----
        mem_rvalid_i = 1'b1;
        mem_gnt_i    = 1'b1;
        mem_rdata_i  = 64'hBAD2;
        tick();
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b0;
        check_eq("spur.idle.mem_req", 64'(mem_req_o), 64'd0);
        tick();
        check_quiet("spur.idle");

        // ---- mem_gnt_i in RESP is ignored ----
        data_req_i  = 1'b1;
        data_addr_i = 64'h7000;
        tick();
        data_req_i = 1'b0;
        mem_gnt_i  = 1'b1;
        tick();
        check_eq("spur.resp.mem_req", 64'(mem_req_o), 64'd0);
        tick();
        mem_gnt_i = 1'b0;
        check_eq("spur.resp.mem_req2", 64'(mem_req_o), 64'd0);
        check_quiet("spur.resp");
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h88;
        tick();
        mem_rvalid_i = 1'b0;
        check_eq("spur.resp.data_rvalid", 64'(data_rvalid_o), 64'd1);
        check_eq("spur.resp.data_rdata",  data_rdata_o,       64'h88);

        // ---- instr request pulsed and dropped while data owns the port ----
        data_req_i  = 1'b1;
        data_addr_i = 64'h8000;
        tick();
        data_req_i   = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 64'h9000;
        settle();
        check_eq("drop.busy.instr_gnt", 64'(instr_gnt_o), 64'd0);
        mem_gnt_i = 1'b1;
        tick();
        instr_req_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h99;
        tick();
        mem_rvalid_i = 1'b0;
        check_eq("drop.data_rvalid", 64'(data_rvalid_o), 64'd1);
        check_eq("drop.instr_gnt",   64'(instr_gnt_o),   64'd0);
        tick();
        check_eq("drop.mem_req",  64'(mem_req_o),  64'd0);
        check_eq("drop.mem_addr", mem_addr_o,      64'h8000);
        tick();
        check_quiet("drop.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound on simulation time so a stuck run still terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single 64-bit memory port between the core's instruction-fetch interface and its data-memory interface. It sits between the core and the unified memory model or bus, and sequences one memory transaction at a time. Each transaction follows a fixed cycle: accept, issue, wait for response, return. It latches the winning request, drives the shared port until the memory grants it, and routes the response back to the owning requester.

## Interface
Parameters:
- ADDR_W, 64, address width of both requesters and the memory port
- DATA_W, 64, read/write data width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- instr_req_i  in  1  fetch request; held until instr_gnt_o
- instr_addr_i  in  ADDR_W  fetch address
- instr_gnt_o  out  1  one-cycle accept pulse for the fetch request
- instr_rvalid_o  out  1  one-cycle pulse; instr_rdata_o valid
- instr_rdata_o  out  DATA_W  fetched data
- data_req_i  in  1  load/store request; held until data_gnt_o
- data_addr_i  in  ADDR_W  data address
- data_byte_en_i  in  2  access size code, forwarded unchanged
- data_wr_i  in  1  1 = store, 0 = load
- data_wr_data_i  in  DATA_W  store data
- data_gnt_o  out  1  one-cycle accept pulse for the data request
- data_rvalid_o  out  1  one-cycle pulse; load data valid, or store complete
- data_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  shared-port request
- mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o  out  ADDR_W/2/1/DATA_W  latched transaction fields
- mem_gnt_i  in  1  memory accepts mem_req_o this cycle
- mem_rvalid_i  in  1  memory response; returned for both reads and writes
- mem_rdata_i  in  DATA_W  response data

## Operation
- FSM states:
  - IDLE: no transaction owned.
  - ISSUE: mem_req_o=1, waiting for mem_gnt_i.
  - RESP: waiting for mem_rvalid_i.
- Transitions:
  - IDLE→ISSUE when any request is present.
  - ISSUE→RESP on mem_gnt_i.
  - RESP→IDLE on mem_rvalid_i.
- In IDLE with a request pending:
  - Arbitrate and assert the winner's gnt combinationally in the same cycle.
  - Latch the winner's addr, byte_en, wr and wr_data into the mem_* registers.
  - Record the owner (0 = instr, 1 = data).
  - Instruction requests latch byte_en = 2'b11 and wr = 0.
- The loser keeps its request asserted. It is not granted until the FSM returns to IDLE.
- Requester fields are sampled only at grant. Changes after grant have no effect.
- A requester dropping req before its grant is legal; nothing is issued for it.
- In RESP, on mem_rvalid_i:
  - Register mem_rdata_i into the owner's rdata_o.
  - Pulse the owner's rvalid_o for one cycle.
- The non-owner's rdata_o holds its previous value.
- mem_rvalid_i in IDLE or ISSUE is ignored. mem_gnt_i outside ISSUE is ignored.
- Only one transaction is outstanding; there is no pipelining of requests.

## Timing
- Reset values:
  - state = IDLE, owner = 0.
  - All outputs 0, including mem_* fields and both rdata_o.
  - last-grant register = instr.
- Fastest transaction: req and gnt in cycle 0; mem_req_o=1 in cycle 1 with mem_gnt_i=1; mem_rvalid_i in cycle 2; rvalid_o and rdata_o in cycle 3.
- Back-to-back: the next grant is possible in the cycle after mem_rvalid_i, because the FSM is in IDLE then. The minimum repeat interval is therefore 3 cycles.
- mem_req_o and the mem_* fields are stable from ISSUE entry until mem_gnt_i. mem_req_o deasserts the cycle after the grant.
- Simultaneous instr_req_i and data_req_i in IDLE resolve per Configuration.
- Reset mid-transaction:
  - FSM returns to IDLE immediately and mem_req_o drops asynchronously.
  - A late mem_rvalid_i after reset release is ignored.
  - No rvalid_o pulse is produced for the aborted transaction.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - On a simultaneous request, grant the requester not granted last.
  - The last-grant register updates on every grant.
- Undefined:
  - Fixed priority: data always wins ties.
  - The last-grant register is not implemented.
- The single-requester case behaves identically in both configurations.

## Test plan
- Single fetch: instr_req_i, addr 0x1000; mem_gnt_i immediate; mem_rvalid_i with 0xDEAD_BEEF_0000_0013 → instr_gnt_o in cycle 0; mem_addr_o=0x1000, mem_wr_o=0 in cycle 1; instr_rvalid_o and matching rdata in cycle 3; data_rvalid_o stays 0.
- Store with 2 wait cycles on mem_gnt_i: addr 0x2008, data 0x55, byte_en 2'b10 → mem_req_o held 3 cycles with fields constant; data_rvalid_o pulses once after mem_rvalid_i.
- Simultaneous requests, held for 4 transactions → fixed priority: D,D,D,D while data stays asserted; with MEM_ARB_ROUND_ROBIN_EN: D,I,D,I, given last-grant = instr after reset.
- Reset asserted in RESP state → mem_req_o=0, outputs cleared; a mem_rvalid_i one cycle after release produces no rvalid_o.
- Spurious mem_rvalid_i in IDLE, and mem_gnt_i in RESP → no state change, no rvalid_o.
- Request dropped before grant (instr_req_i pulsed while data owns the port) → no instr transaction issued; FSM returns to IDLE.
